// File: rtl/sprite_compositor.sv
// N-channel sprite compositor. Each channel does its own hit test and address generation.
// The result is transparency-keyed and mixed by fixed priority over the background, with per-frame collision flags.

module sprite_chan #(
    parameter int DEPTH_BIT = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_sync,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_field,
    input  logic [DEPTH_BIT-1:0] cfg_data,
    input  logic [9:0]           col,
    input  logic [8:0]           row,
    output logic                 hit,
    output logic [DEPTH_BIT-1:0] addr
);
    localparam int AW = (DEPTH_BIT > 20) ? DEPTH_BIT : 20;

    typedef struct packed {
        logic [9:0]           posx;
        logic [8:0]           posy;
        logic [9:0]           width;
        logic [8:0]           height;
        logic [DEPTH_BIT-1:0] mem_start;
        logic                 en;
    } geom_t;

    geom_t shadow, shadow_nxt, active;

    // Commit takes shadow_nxt so a write landing on the frame_sync cycle is included.
    always_comb begin
        shadow_nxt = shadow;
        if (cfg_we) begin
            case (cfg_field)
                3'd0:    shadow_nxt.posx      = cfg_data[9:0];
                3'd1:    shadow_nxt.posy      = cfg_data[8:0];
                3'd2:    shadow_nxt.width     = cfg_data[9:0];
                3'd3:    shadow_nxt.height    = cfg_data[8:0];
                3'd4:    shadow_nxt.mem_start = cfg_data;
                3'd5:    shadow_nxt.en        = cfg_data[0];
                default: ;
            endcase
        end
    end

    logic [10:0]   x_end;
    logic [9:0]    y_end;
    logic [9:0]    dx;
    logic [8:0]    dy;
    logic [AW-1:0] off;
    logic          hit_c;

    assign x_end = {1'b0, active.posx} + {1'b0, active.width};
    assign y_end = {1'b0, active.posy} + {1'b0, active.height};
    assign hit_c = active.en && (col >= active.posx) && ({1'b0, col} < x_end)
                && (row >= active.posy) && ({1'b0, row} < y_end);
    assign dx    = col - active.posx;
    assign dy    = row - active.posy;
    assign off   = AW'(dy) * AW'(active.width) + AW'(dx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            hit    <= 1'b0;
            addr   <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (frame_sync)
                active <= shadow_nxt;
            hit  <= hit_c;
            addr <= hit_c ? active.mem_start + off[DEPTH_BIT-1:0] : active.mem_start;
        end
    end
endmodule

module sprite_compositor #(
    parameter int          N_SPR     = 4,
    parameter int          DEPTH_BIT = 19,
    parameter logic [11:0] TRANS_KEY = 12'h000,
    parameter int          SEL_W     = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_valid,
    input  logic [9:0]                 col,
    input  logic [8:0]                 row,
    input  logic                       frame_sync,
    input  logic [11:0]                bg_data,
    input  logic                       cfg_we,
    input  logic [SEL_W-1:0]           cfg_sel,
    input  logic [2:0]                 cfg_field,
    input  logic [DEPTH_BIT-1:0]       cfg_data,
    output logic [N_SPR*DEPTH_BIT-1:0] mem_addr,
    input  logic [N_SPR*12-1:0]        mem_data,
    output logic [11:0]                pix_out,
    output logic                       pix_out_valid,
    output logic [N_SPR-1:0]           coll_status
);
    localparam int STAGES = 3;

    logic [STAGES:1]                  vld_pipe;
    logic [N_SPR-1:0]                 hit_s1, hit_s2, opaque, coll_set, coll_acc;
    logic [N_SPR-1:0][DEPTH_BIT-1:0]  addr_v;
    logic [N_SPR-1:0][11:0]           spr_px;
    logic [11:0]                      bg_s1, bg_s2, mix;

    assign mem_addr = addr_v;
    assign spr_px   = mem_data;

    for (genvar i = 0; i < N_SPR; i++) begin : g_chan
        sprite_chan #(.DEPTH_BIT(DEPTH_BIT)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_sync (frame_sync),
            .cfg_we     (cfg_we && (cfg_sel == SEL_W'(i))),
            .cfg_field  (cfg_field),
            .cfg_data   (cfg_data),
            .col        (col),
            .row        (row),
            .hit        (hit_s1[i]),
            .addr       (addr_v[i])
        );
        assign opaque[i] = hit_s2[i] && (spr_px[i] != TRANS_KEY);
    end

    // Walk from the highest index down so the lowest-index opaque channel wins.
    always_comb begin
        mix = bg_s2;
        for (int i = N_SPR - 1; i >= 0; i--)
            if (opaque[i]) mix = spr_px[i];
    end

    always_comb begin
        coll_set = '0;
        for (int i = 0; i < N_SPR; i++)
            coll_set[i] = vld_pipe[2] && opaque[i] && |(opaque & ~(N_SPR'(1) << i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe    <= '0;
            hit_s2      <= '0;
            bg_s1       <= '0;
            bg_s2       <= '0;
            pix_out     <= '0;
            coll_acc    <= '0;
            coll_status <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
            hit_s2   <= hit_s1;
            bg_s1    <= bg_data;
            bg_s2    <= bg_s1;
            pix_out  <= vld_pipe[2] ? mix : 12'h000;
            if (frame_sync) begin
                coll_status <= coll_acc | coll_set;
                coll_acc    <= '0;
            end else begin
                coll_acc <= coll_acc | coll_set;
            end
        end
    end

    assign pix_out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed and randomized bench for sprite_compositor.
// The reference model tracks geometry and predicts each pixel's output three cycles ahead.

module tb_sprite_compositor;
    localparam int          N   = 4;
    localparam int          DB  = 19;
    localparam logic [11:0] KEY = 12'h000;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            pix_valid = 1'b0, frame_sync = 1'b0, cfg_we = 1'b0;
    logic [9:0]      col = '0;
    logic [8:0]      row = '0;
    logic [11:0]     bg_data = '0;
    logic [1:0]      cfg_sel = '0;
    logic [2:0]      cfg_field = '0;
    logic [DB-1:0]   cfg_data = '0;
    logic [N*DB-1:0] mem_addr;
    logic [N*12-1:0] mem_data = '0;
    logic [11:0]     pix_out;
    logic            pix_out_valid;
    logic [N-1:0]    coll_status;

    int checks = 0, errors = 0;

    typedef struct {
        bit            v;
        logic [11:0]   pix;
        logic [DB-1:0] addr [N];
        logic [N-1:0]  coll;
    } rec_t;

    rec_t         q[$];
    int           sh [N][6];
    int           act[N][6];
    logic [N-1:0] m_acc, m_coll;
    bit           force_en [N];
    logic [11:0]  force_val[N];

    always #5 clk = ~clk;

    sprite_compositor #(.N_SPR(N), .DEPTH_BIT(DB), .TRANS_KEY(KEY)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .col(col), .row(row),
        .frame_sync(frame_sync), .bg_data(bg_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .coll_status(coll_status)
    );

    function automatic logic [11:0] memval(int i, int a);
        if (force_en[i]) return force_val[i];
        if (((a + i) % 4) == 0) return KEY;
        return 12'((a * 7 + i * 291 + 1) ^ (a >> 5));
    endfunction

    // Sprite memories: one-cycle synchronous read.
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            mem_data[i*12 +: 12] <= memval(i, int'(mem_addr[i*DB +: DB]));

    function automatic int fmask(int f);
        case (f)
            0, 2:    return 1023;
            1, 3:    return 511;
            4:       return (1 << DB) - 1;
            default: return 1;
        endcase
    endfunction

    function automatic rec_t predict();
        rec_t         r;
        logic [11:0]  px[N];
        logic [N-1:0] op;
        int           c, rr, first;
        c = int'(col);
        rr = int'(row);
        op = '0;
        first = -1;
        r.v = pix_valid;
        r.pix = 12'h000;
        r.coll = '0;
        for (int i = 0; i < N; i++) begin
            bit h;
            h = act[i][5] != 0 && c >= act[i][0] && c < act[i][0] + act[i][2]
                && rr >= act[i][1] && rr < act[i][1] + act[i][3];
            r.addr[i] = h ? DB'((act[i][4] + (rr - act[i][1]) * act[i][2] + (c - act[i][0])) % (1 << DB))
                          : DB'(act[i][4]);
            px[i] = memval(i, int'(r.addr[i]));
            op[i] = h && (px[i] != KEY);
            if (op[i] && first < 0) first = i;
        end
        if (pix_valid) begin
            r.pix = (first >= 0) ? px[first] : bg_data;
            if ($countones(op) >= 2) r.coll = op;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rec_t z;
        z.v = 1'b0;
        z.pix = '0;
        z.coll = '0;
        for (int i = 0; i < N; i++) z.addr[i] = '0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 6; j++) begin
                sh[i][j] = 0;
                act[i][j] = 0;
            end
        m_acc = '0;
        m_coll = '0;
    endtask

    // One pixel-clock cycle with the current inputs, checked against the model.
    task automatic cyc();
        rec_t r, f;
        r = predict();
        q.push_back(r);
        @(posedge clk);
        if (cfg_we && cfg_field < 3'd6)
            sh[cfg_sel][cfg_field] = int'(cfg_data) & fmask(int'(cfg_field));
        f = q.pop_front();
        if (frame_sync) begin
            m_coll = m_acc | f.coll;
            m_acc = '0;
            act = sh;
        end else begin
            m_acc = m_acc | f.coll;
        end
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("mem_addr%0d", i), 32'(mem_addr[i*DB +: DB]), 32'(r.addr[i]));
        chk("pix_out", 32'(pix_out), 32'(f.pix));
        chk("pix_out_valid", 32'(pix_out_valid), 32'(f.v));
        chk("coll_status", 32'(coll_status), 32'(m_coll));
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic pix(int c, int r_, logic [11:0] bg);
        pix_valid = 1'b1;
        col = 10'(c);
        row = 9'(r_);
        bg_data = bg;
        cyc();
        pix_valid = 1'b0;
    endtask

    task automatic cfg(int sel, int field, int data);
        cfg_we = 1'b1;
        cfg_sel = 2'(sel);
        cfg_field = 3'(field);
        cfg_data = DB'(data);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic geom(int sel, int px, int py, int w, int h, int ms);
        cfg(sel, 0, px);
        cfg(sel, 1, py);
        cfg(sel, 2, w);
        cfg(sel, 3, h);
        cfg(sel, 4, ms);
        cfg(sel, 5, 1);
    endtask

    task automatic fsync();
        frame_sync = 1'b1;
        cyc();
        frame_sync = 1'b0;
    endtask

    task automatic set_force(int i, bit en, logic [11:0] v);
        force_en[i] = en;
        force_val[i] = v;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_force(i, 1'b0, 12'h000);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_out", 32'(pix_out), 32'h0);
        chk("rst_valid", 32'(pix_out_valid), 32'h0);
        chk("rst_coll", 32'(coll_status), 32'h0);
        chk("rst_mem_addr_zero", 32'(mem_addr == '0), 32'h1);
        rst_n = 1'b1;
        model_reset();

        // Background pass-through, exactly 3 cycles latency
        pix(10, 10, 12'hABC);
        idle(1);
        chk("bg_not_early", 32'(pix_out_valid), 32'h0);
        idle(1);
        chk("bg_pix", 32'(pix_out), 32'hABC);
        chk("bg_valid", 32'(pix_out_valid), 32'h1);
        chk("bg_mem_addr_zero", 32'(mem_addr == '0), 32'h1);

        // Single sprite hit and exclusive right edge
        geom(0, 100, 50, 20, 10, 1000);
        fsync();
        set_force(0, 1'b1, 12'hF00);
        pix(105, 52, 12'h111);
        chk("ch0_addr_1045", 32'(mem_addr[0 +: DB]), 32'd1045);
        idle(2);
        chk("ch0_pix_f00", 32'(pix_out), 32'hF00);
        pix(120, 52, 12'h5A5);
        idle(2);
        chk("ch0_right_edge_bg", 32'(pix_out), 32'h5A5);

        // Overlap priority, transparency and collision
        geom(2, 100, 50, 20, 10, 2000);
        fsync();
        set_force(0, 1'b1, 12'h0F0);
        set_force(2, 1'b1, 12'h00F);
        pix(105, 52, 12'h123);
        idle(2);
        chk("prio_ch0", 32'(pix_out), 32'h0F0);
        fsync();
        chk("coll_0101", 32'(coll_status), 32'b0101);
        fsync();
        chk("coll_cleared", 32'(coll_status), 32'b0000);
        pix(105, 52, 12'h123);
        idle(1);
        fsync();
        chk("coll_same_cycle", 32'(coll_status), 32'b0101);
        set_force(0, 1'b1, KEY);
        pix(105, 52, 12'h123);
        idle(2);
        chk("ch0_transparent", 32'(pix_out), 32'h00F);
        set_force(2, 1'b1, KEY);
        pix(105, 52, 12'h123);
        idle(2);
        chk("both_transparent", 32'(pix_out), 32'h123);

        // Shadow commit and write-through on frame_sync
        for (int i = 0; i < N; i++) set_force(i, 1'b0, 12'h000);
        geom(1, 200, 50, 20, 10, 3000);
        fsync();
        cfg(1, 0, 300);
        pix(205, 52, 12'h222);
        chk("shadow_old_hit", 32'(mem_addr[DB +: DB]), 32'd3045);
        pix(305, 52, 12'h222);
        chk("shadow_new_nohit", 32'(mem_addr[DB +: DB]), 32'd3000);
        cfg_we = 1'b1;
        cfg_sel = 2'd1;
        cfg_field = 3'd1;
        cfg_data = DB'(60);
        fsync();
        cfg_we = 1'b0;
        pix(305, 62, 12'h222);
        chk("write_through", 32'(mem_addr[DB +: DB]), 32'd3045);
        idle(2);

        // Right-edge clip, no wrap to next row, ignored fields
        geom(3, 630, 100, 20, 5, 5000);
        fsync();
        for (int c = 630; c < 640; c++) begin
            pix(c, 100, 12'h333);
            chk("clip_addr", 32'(mem_addr[3*DB +: DB]), 32'(5000 + c - 630));
        end
        pix(0, 101, 12'h333);
        chk("clip_no_wrap", 32'(mem_addr[3*DB +: DB]), 32'd5000);
        cfg(3, 6, 77);
        cfg(3, 7, 88);
        fsync();
        pix(635, 100, 12'h333);
        chk("field67_ignored", 32'(mem_addr[3*DB +: DB]), 32'd5005);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            pix_valid = ($urandom_range(0, 9) < 8);
            col = 10'($urandom_range(0, 639));
            row = 9'($urandom_range(0, 479));
            bg_data = 12'($urandom);
            frame_sync = ($urandom_range(0, 49) == 0);
            cfg_we = ($urandom_range(0, 19) == 0);
            cfg_sel = 2'($urandom);
            cfg_field = 3'($urandom);
            case (cfg_field)
                3'd0:    cfg_data = DB'($urandom_range(0, 639));
                3'd1:    cfg_data = DB'($urandom_range(0, 479));
                3'd2:    cfg_data = DB'($urandom_range(0, 200));
                3'd3:    cfg_data = DB'($urandom_range(0, 150));
                3'd5:    cfg_data = DB'($urandom_range(0, 3) != 0);
                default: cfg_data = DB'($urandom);
            endcase
            cyc();
        end
        pix_valid = 1'b0;
        frame_sync = 1'b0;
        cfg_we = 1'b0;
        idle(3);

        // Asynchronous reset in the middle of a busy line
        geom(0, 100, 50, 20, 10, 1000);
        geom(2, 100, 50, 20, 10, 2000);
        fsync();
        set_force(0, 1'b1, 12'hF00);
        set_force(2, 1'b1, 12'h00F);
        pix(105, 52, 12'h444);
        idle(2);
        fsync();
        chk("pre_rst_coll", 32'(coll_status[0]), 32'h1);
        pix_valid = 1'b1;
        col = 10'd106;
        row = 9'd53;
        bg_data = 12'h444;
        idle(3);
        chk("pre_rst_pix", 32'(pix_out), 32'hF00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pix_out", 32'(pix_out), 32'h0);
        chk("async_valid", 32'(pix_out_valid), 32'h0);
        chk("async_coll", 32'(coll_status), 32'h0);
        chk("async_mem_addr", 32'(mem_addr == '0), 32'h1);
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) set_force(i, 1'b0, 12'h000);
        pix(105, 52, 12'h9C3);
        chk("post_rst_disabled_addr", 32'(mem_addr[0 +: DB]), 32'd0);
        idle(2);
        chk("post_rst_bg", 32'(pix_out), 32'h9C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
